pmu_result_drain: RTL
=====================

Name: pmu_result_drain

Overview:
- Downstream consumer of the PMU's flat result bus P_flat (NUM_LANES lanes, each OUT_W = DATA_WIDTH+1 bits).
- On a capture pulse, snapshots the whole bus, then streams the lanes out one per handshake, lane 0 first, over a valid/ready interface.
- Gives the narrow board-level pins sequential access to every lane, not just lane 0.

Parameters:
- NUM_LANES, 240, number of PMU lanes in P_flat.
- DATA_WIDTH, 16, PMU operand width; lane width OUT_W = DATA_WIDTH+1 (localparam, not overridable).
- IDX_W, 8, lane index width; must satisfy 2**IDX_W >= NUM_LANES.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- P_flat  input  NUM_LANES*OUT_W  PMU result bus; lane i = bits [(i+1)*OUT_W-1 -: OUT_W].
- capture  input  1  single-cycle request to snapshot P_flat and begin draining.
- busy  output  1  high from the cycle after an accepted capture until done.
- out_valid  output  1  out_data/out_idx hold a valid lane.
- out_ready  input  1  consumer accepts the current lane.
- out_data  output  OUT_W  current lane value.
- out_idx  output  IDX_W  current lane number.
- out_last  output  1  high with out_valid when out_idx == NUM_LANES-1.
- done  output  1  one-cycle pulse after the last lane is accepted.
- overrun  output  1  sticky; set when capture arrives while not IDLE.

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst).
- Reset: state=IDLE; busy, out_valid, out_last, done and overrun = 0; out_idx = 0; out_data = 0. The snapshot register is not reset.
- Reset mid-stream aborts immediately. No done pulse is issued, and the next cycle is IDLE.

FSM states:
- IDLE:
  - capture=1 → snapshot <= P_flat, idx <= 0, go to STREAM.
  - Latency: out_valid rises the cycle after capture.
- STREAM:
  - out_valid=1; out_data = snapshot lane idx; out_idx = idx; busy=1.
  - On out_valid && out_ready:
    - idx < NUM_LANES-1 → idx+1.
    - idx == NUM_LANES-1 → go to DONE.
  - No handshake → hold idx and outputs. out_data is stable while valid && !ready.
  - Full throughput: with out_ready held high, one lane per cycle; NUM_LANES cycles from first valid to last accept.
- DONE: done=1 and busy=1 for exactly one cycle, out_valid=0, then IDLE.
- Outputs outside STREAM: out_data and out_idx are 0; out_valid and out_last are 0.

Rules:
- Capture while in STREAM or DONE is ignored (snapshot unchanged) and sets overrun. overrun clears only on rst.
- Capture and a last-lane accept in the same cycle: the capture is ignored and overrun is set. A capture arriving in DONE is likewise ignored; it must come in IDLE.
- P_flat changes after the snapshot do not affect the streamed data.
- Widths:
  - Lane values pass unmodified; no arithmetic on the data path.
  - idx never exceeds NUM_LANES-1, so there is no wrap.
  - Sum path (feature only) is OUT_W+IDX_W bits wide and cannot overflow for NUM_LANES <= 2**IDX_W.

Optional Feature:
Macro PMU_DRAIN_SUM_EN.
- Defined:
  - Adds output sum_out [OUT_W+IDX_W-1:0] and output sum_valid [1].
  - The accumulator clears on accepted capture and adds out_data, zero-extended, on every accepted lane.
  - On the DONE cycle, sum_valid=1 and sum_out = total of all lanes; sum_out holds that value until the next accepted capture or rst.
  - sum_valid is high only in the DONE cycle. Reset value of both is 0.
- Undefined: the ports and accumulator do not exist; all other behaviour is identical.

Test Plan:
- Reset, capture and full-rate drain: rst held 2 cycles → all outputs 0. Then P_flat lane i = i*3, capture pulse, out_ready=1 → out_valid next cycle, then 240 beats of out_idx 0..239 with out_data 0,3,…,717. out_last only on beat 239. done pulses the cycle after, then busy=0.
- Backpressure: toggle out_ready 1/0 every cycle → each lane is held stable while ready=0, no lane is lost or duplicated, and 240 accepts occur in 479 cycles.
- Snapshot isolation and overrun: change P_flat to all 1s and pulse capture mid-stream → streamed values still i*3, and overrun=1 until rst.
- Reset mid-stream: assert rst at out_idx=100 → the next cycle has out_valid=0 and busy=0 with no done pulse. A new capture restarts at lane 0.
- Max value (PMU_DRAIN_SUM_EN defined): every lane = 0x1FFFF → sum_out = 240*131071 = 31457040 with sum_valid high in the DONE cycle. With the macro undefined the build compiles without sum ports.

Source files
------------

// File: rtl/pmu_result_drain.sv
// Snapshots the PMU flat result bus on capture and drains it one lane per valid/ready beat.
// Optional running lane total on sum_out/sum_valid when PMU_DRAIN_SUM_EN is defined.
module pmu_result_drain #(
  parameter int unsigned NUM_LANES  = 240,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_W      = 8,
  localparam int unsigned OUT_W     = DATA_WIDTH + 1,
  localparam int unsigned SUM_W     = OUT_W + IDX_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LANES*OUT_W-1:0] P_flat,
  input  logic                       capture,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last,
  output logic                       done,
  output logic                       overrun
`ifdef PMU_DRAIN_SUM_EN
  ,
  output logic [SUM_W-1:0]           sum_out,
  output logic                       sum_valid
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [OUT_W-1:0] snap [NUM_LANES];

  logic             start;
  logic             accept;
  logic [IDX_W-1:0] idx_n;
  logic [OUT_W-1:0] data_n;
  logic             valid_n;
  logic             last_n;
  logic             done_n;
  logic             busy_n;
  logic             overrun_n;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and next registered outputs
  always_comb begin
    state_n   = state;
    idx_n     = out_idx;
    data_n    = out_data;
    start     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
          start   = 1'b1;
          state_n = STREAM;
          idx_n   = '0;
          data_n  = P_flat[OUT_W-1:0];
        end
      end
      STREAM: begin
        if (out_ready) begin
          accept = 1'b1;
          if (out_idx == LAST_IDX) begin
            state_n = DONE;
            idx_n   = '0;
            data_n  = '0;
          end else begin
            idx_n  = out_idx + IDX_W'(1);
            data_n = snap[out_idx + IDX_W'(1)];
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        idx_n   = '0;
        data_n  = '0;
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
        data_n  = '0;
      end
    endcase
    valid_n   = (state_n == STREAM);
    last_n    = valid_n && (idx_n == LAST_IDX);
    done_n    = (state_n == DONE);
    busy_n    = (state_n != IDLE);
    // Any capture outside IDLE is dropped and flagged
    overrun_n = overrun | (capture && (state != IDLE));
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      out_idx   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_idx   <= idx_n;
      out_data  <= data_n;
      out_valid <= valid_n;
      out_last  <= last_n;
      done      <= done_n;
      busy      <= busy_n;
      overrun   <= overrun_n;
    end
  end

  // Snapshot holds the lanes for the whole drain; deliberately not reset
  always_ff @(posedge clk) begin
    if (start) begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        snap[i] <= P_flat[i*OUT_W +: OUT_W];
      end
    end
  end

`ifdef PMU_DRAIN_SUM_EN
  // Accumulator doubles as sum_out so the total holds until the next capture
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= done_n;
      if (start)       sum_out <= '0;
      else if (accept) sum_out <= sum_out + SUM_W'(out_data);
    end
  end
`endif

endmodule
